countdown_timer: RTL and testbench
==================================

// Module: countdown_timer
// PURPOSE
//  Loadable down-counter/timer; the down-counting counterpart of the free-running up-counter.
//  Counts down from a programmed value on qualified ticks and emits a one-cycle borrow pulse at terminal count.
//  Supports one-shot or auto-reload, start/pause control and status flags.
//  Sits beside the up-counter in timing logic; borrow can drive another timer's en for cascading.
// PARAMETERS
//  WIDTH  8  bit width of count, load_value and internal reload register
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      asynchronous, active-high
//  load         in   1      capture load_value into count and reload register
//  load_value   in   WIDTH  value captured on load
//  start        in   1      begin/restart counting (level, sampled each cycle)
//  pause        in   1      hold count while high (RUN <-> PAUSED)
//  auto_reload  in   1      1: reload on terminal count and continue; 0: one-shot
//  en           in   1      tick qualifier; count changes only on en=1 in RUN
//  count        out  WIDTH  current count value (registered)
//  borrow       out  1      one-cycle pulse at terminal count (registered)
//  busy         out  1      high in RUN or PAUSED
//  done         out  1      high in DONE
// BEHAVIOUR
//  Reset (async): state=IDLE, count=0, reload_reg=0, borrow=0; so busy=0, done=0.
//  States: IDLE, RUN, PAUSED, DONE. busy/done decoded from state, no extra latency.
//  Priority per edge: reset > load > pause > start > tick(en).
//  load (any state): count<=load_value, reload_reg<=load_value, state<=IDLE, borrow<=0.
//  IDLE: start -> RUN; count unchanged (start from count=0 is legal).
//  RUN, pause=1 -> PAUSED, count frozen, en ignored.
//  RUN, en=1, count!=0 -> count<=count-1, borrow<=0.
//  RUN, en=1, count==0 -> borrow<=1 for exactly one cycle, then:
//    auto_reload=1 and reload_reg!=0: count<=reload_reg, stay RUN.
//    auto_reload=1 and reload_reg==0: stay RUN; count stays 0; borrow fires on every en.
//    auto_reload=0: state<=DONE, count stays 0.
//  RUN, en=0: hold; borrow<=0.
//  Period: N+1 en ticks per borrow for loaded value N; gaps in en stretch the period, no ticks are lost or double-counted.
//  PAUSED: pause=0 -> RUN; resumes on next en with no count change on the resume edge.
//  DONE: start -> count<=reload_reg, RUN; otherwise hold count=0, done=1.
//  borrow is 0 in every cycle not described above, including load and pause edges.
//  Arithmetic: unsigned WIDTH bits; decrement never underflows (0 is the terminal check).
//  auto_reload is sampled only at terminal count; a change mid-count takes effect at the next terminal.
//  Reset mid-operation: immediate return to reset values; no borrow is emitted.
// STRUCTURE
//  timer_pkg.sv: typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSED, ST_DONE} timer_state_t.
//  Single module: one sequential block (state, count, reload_reg, borrow) plus combinational next-state logic.
//  No sub-module; cascading is done at the instantiating level (borrow -> en).
// TESTING
//  1. Reset asserted mid-RUN at count=5 -> count=0, state IDLE, borrow=0, busy=0 in the same cycle.
//  2. load 3, start, en=1 continuous, auto_reload=0 -> count 3,2,1,0; borrow=1 on the 4th en edge; done=1; count holds 0.
//  3. load 2, auto_reload=1, en=1 continuous -> borrow every 3 cycles for 4 periods; count sequence 2,1,0,2,1,0...
//  4. load 5, RUN, pause high for 4 cycles with en=1 -> count frozen; resumes decrementing after pause drops; total en count to borrow=6.
//  5. load asserted together with en at count=0 in RUN -> no borrow; count=load_value; state IDLE.
//  6. DONE then start -> count=reload_reg, RUN; load 0 with start, auto_reload=1 -> borrow on every en cycle.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types for the countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSED,
    ST_DONE
  } timer_state_t;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot / auto-reload modes, pause control and
// a one-cycle borrow pulse at terminal count. Borrow may feed another timer's
// en input for cascading.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  input  logic             auto_reload,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  timer_state_t     state_q, state_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [WIDTH-1:0] count_d;
  logic             borrow_d;

  // Next-state: load beats pause, pause beats start, start beats the en tick.
  // Borrow defaults low so it only ever lasts one cycle.
  always_comb begin
    state_d  = state_q;
    count_d  = count;
    reload_d = reload_q;
    borrow_d = 1'b0;
    if (load) begin
      count_d  = load_value;
      reload_d = load_value;
      state_d  = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!pause && start) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSED;
          end else if (en) begin
            if (count != '0) begin
              count_d = count - WIDTH'(1);
            end else begin
              // Terminal count: auto_reload is only consulted here, so a
              // mid-count change waits for the next terminal.
              borrow_d = 1'b1;
              if (auto_reload) begin
                // A zero reload value keeps count at 0 and borrows every en.
                if (reload_q != '0) count_d = reload_q;
              end else begin
                state_d = ST_DONE;
              end
            end
          end
        end
        ST_PAUSED: begin
          // Resume edge never moves the count; the next en does.
          if (!pause) state_d = ST_RUN;
        end
        ST_DONE: begin
          if (!pause && start) begin
            count_d = reload_q;
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, count, reload value and borrow pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count    <= '0;
      reload_q <= '0;
      borrow   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count    <= count_d;
      reload_q <= reload_d;
      borrow   <= borrow_d;
    end
  end

  assign busy = (state_q == ST_RUN) || (state_q == ST_PAUSED);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios followed by a
// randomized phase, all checked against a behavioural model of the timer.
module tb_countdown_timer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             pause;
  logic             auto_reload;
  logic             en;
  logic [WIDTH-1:0] count;
  logic             borrow;
  logic             busy;
  logic             done;

  countdown_timer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .auto_reload(auto_reload), .en(en),
    .count(count), .borrow(borrow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode is a plain activity label, count/reload are ints.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
  int m_mode   = M_IDLE;
  int m_count  = 0;
  int m_reload = 0;
  int m_borrow = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_count = 0; m_reload = 0; m_borrow = 0;
  endtask

  // One clock edge of the timer as described in words: load wins, then
  // pause, then start, then an en tick.
  task automatic model_edge();
    m_borrow = 0;
    if (reset) begin
      model_reset();
    end else if (load) begin
      m_count = int'(load_value); m_reload = int'(load_value); m_mode = M_IDLE;
    end else if (m_mode == M_RUN) begin
      if (pause) m_mode = M_PAUSED;
      else if (en) begin
        if (m_count > 0) m_count = m_count - 1;
        else begin
          m_borrow = 1;
          if (!auto_reload) m_mode = M_DONE;
          else if (m_reload > 0) m_count = m_reload;
        end
      end
    end else if (m_mode == M_PAUSED) begin
      if (!pause) m_mode = M_RUN;
    end else if (!pause && start) begin
      if (m_mode == M_DONE) m_count = m_reload;
      m_mode = M_RUN;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"},  32'(count),  32'(m_count));
    chk({tag, ".borrow"}, 32'(borrow), 32'(m_borrow));
    chk({tag, ".busy"},   32'(busy),   32'((m_mode == M_RUN) || (m_mode == M_PAUSED)));
    chk({tag, ".done"},   32'(done),   32'(m_mode == M_DONE));
  endtask

  // Advance one clock; inputs were driven 1 time unit after the previous edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    load = 0; start = 0; pause = 0; en = 0;
  endtask

  task automatic do_load(input int v, input string tag);
    idle_inputs(); load = 1; load_value = WIDTH'(v);
    step(tag);
    load = 0;
  endtask

  int ne;
  int seen;

  initial begin
    reset = 1; idle_inputs(); load_value = '0; auto_reload = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 0;

    // 1: async reset mid-run at count=5
    do_load(8, "t1.load");
    start = 1; step("t1.start"); start = 0;
    en = 1;
    repeat (3) step("t1.run");
    chk("t1.count5", 32'(count), 32'd5);
    reset = 1; #2;
    model_reset();
    check_all("t1.async");
    step("t1.held");
    reset = 0; en = 0;

    // 2: one-shot from 3, borrow on 4th en edge, then DONE holding 0
    auto_reload = 0;
    do_load(3, "t2.load");
    start = 1; step("t2.start"); start = 0;
    en = 1; ne = 0; seen = 0;
    repeat (6) begin
      step("t2.run"); ne++;
      if (borrow) seen = ne;
    end
    chk("t2.borrow_edge", 32'(seen), 32'd4);
    chk("t2.done", 32'(done), 32'd1);

    // 6a: DONE then start reloads and runs
    en = 0; start = 1; step("t6.restart"); start = 0;
    chk("t6.reloaded", 32'(count), 32'd3);

    // 3: auto-reload from 2, borrow every 3 en cycles over 4 periods
    auto_reload = 1;
    do_load(2, "t3.load");
    start = 1; step("t3.start"); start = 0;
    en = 1; ne = 0; seen = 0;
    repeat (12) begin
      step("t3.run"); ne++;
      if (borrow) begin
        seen++;
        chk("t3.period", 32'(ne % 3), 32'd0);
      end
    end
    chk("t3.nborrow", 32'(seen), 32'd4);

    // 4: pause for 4 cycles mid-count; 6 effective ticks to borrow
    auto_reload = 0;
    do_load(5, "t4.load");
    start = 1; step("t4.start"); start = 0;
    en = 1; ne = 0;
    repeat (2) begin step("t4.pre"); ne++; end
    pause = 1;
    repeat (4) step("t4.paused");
    chk("t4.frozen", 32'(count), 32'd3);
    pause = 0; step("t4.resume");
    chk("t4.resume_cnt", 32'(count), 32'd3);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step("t4.post"); ne++;
      if (borrow) seen = ne;
    end
    chk("t4.ticks", 32'(seen), 32'd6);

    // 5: load together with en at terminal count in RUN
    auto_reload = 1;
    do_load(1, "t5.load");
    start = 1; step("t5.start"); start = 0;
    en = 1; step("t5.dec");
    chk("t5.at0", 32'(count), 32'd0);
    load = 1; load_value = 8'd7; step("t5.loaden"); load = 0;
    chk("t5.noborrow", 32'(borrow), 32'd0);
    chk("t5.cnt", 32'(count), 32'd7);
    chk("t5.idle", 32'(busy), 32'd0);

    // 6b: load 0 with start, auto-reload -> borrow on every en
    en = 0; load = 1; start = 1; load_value = '0; step("t6.load0"); load = 0;
    step("t6.start0"); start = 0;
    en = 1;
    repeat (4) begin
      step("t6.every");
      chk("t6.borrow", 32'(borrow), 32'd1);
    end
    en = 0;

    // Random phase
    for (int i = 0; i < 800; i++) begin
      load        = ($urandom_range(0, 19) == 0);
      load_value  = WIDTH'($urandom_range(0, 6));
      start       = ($urandom_range(0, 3) == 0);
      pause       = ($urandom_range(0, 7) == 0);
      en          = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 15) == 0) auto_reload = ~auto_reload;
      if ($urandom_range(0, 199) == 0) begin
        reset = 1; #1;
        model_reset();
        check_all("rnd.async");
        step("rnd.reset");
        reset = 0;
      end else begin
        step("rnd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
